// File: rtl/synth_voice_pkg.sv
// Shared constants and FSM encoding for the synth voice allocator.
// Defaults match the 24-output voice demux.
package synth_voice_pkg;
  localparam int NUM_VOICES_DEF = 24;
  localparam int SEL_W_DEF = 5;
  localparam logic [4:0] SEL_ALL_OFF = 5'h1F;
  localparam int GATE_BIT = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_e;
endpackage

// File: rtl/voice_age_tracker.sv
// Per-voice saturating age counters plus running-max comparator.
// Only built when VOICE_STEAL_EN is defined.
module voice_age_tracker
  import synth_voice_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int SEL_W = SEL_W_DEF,
  parameter int AGE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scan_clr_i,
  input  logic                  scan_en_i,
  input  logic [SEL_W-1:0]      scan_idx_i,
  input  logic [NUM_VOICES-1:0] gate_i,
  input  logic                  bump_i,
  input  logic [SEL_W-1:0]      bump_idx_i,
  input  logic                  clr_all_i,
  output logic                  found_o,
  output logic [SEL_W-1:0]      idx_o
);

  logic [AGE_W-1:0] age_q [NUM_VOICES];
  logic [AGE_W-1:0] max_q;
  logic [AGE_W-1:0] cur_age;
  logic             found_q;
  logic [SEL_W-1:0] idx_q;

  assign cur_age = age_q[scan_idx_i];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VOICES; i++) age_q[i] <= '0;
    end else if (clr_all_i) begin
      for (int i = 0; i < NUM_VOICES; i++) age_q[i] <= '0;
    end else if (bump_i) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (SEL_W'(i) == bump_idx_i)
          age_q[i] <= '0;
        else if (gate_i[i] && age_q[i] != '1)
          age_q[i] <= age_q[i] + 1'b1;
      end
    end
  end

  // Strict greater-than keeps the lowest index on ties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      found_q <= 1'b0;
      max_q   <= '0;
      idx_q   <= '0;
    end else if (scan_clr_i) begin
      found_q <= 1'b0;
      max_q   <= '0;
      idx_q   <= '0;
    end else if (scan_en_i && gate_i[scan_idx_i] &&
                 (!found_q || cur_age > max_q)) begin
      found_q <= 1'b1;
      max_q   <= cur_age;
      idx_q   <= scan_idx_i;
    end
  end

  assign found_o = found_q;
  assign idx_o   = idx_q;

endmodule

// File: rtl/voice_allocator.sv
// Voice allocator feeding the voice demux select/data pair.
// Define VOICE_STEAL_EN to steal the oldest gated voice when full.
module voice_allocator
  import synth_voice_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int SEL_W = SEL_W_DEF,
  parameter int AGE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ev_valid,
  output logic                  ev_ready,
  input  logic                  ev_on,
  input  logic [6:0]            ev_note,
  input  logic                  ev_all_off,
  output logic [SEL_W-1:0]      wr_sel,
  output logic [7:0]            wr_data,
  output logic [NUM_VOICES-1:0] voices_active,
  output logic                  ev_dropped
);

  state_e state_q, state_d;
  logic [SEL_W-1:0] idx_q;
  logic on_q, all_q;
  logic [6:0] note_q;
  logic [6:0] vnote_q [NUM_VOICES];
  logic [NUM_VOICES-1:0] gate_q;
  logic hit_ok_q, free_ok_q;
  logic [SEL_W-1:0] hit_idx_q, free_idx_q;
  logic [SEL_W-1:0] wr_sel_q;
  logic [7:0] wr_data_q;
  logic drop_q;

  logic accept, last, in_scan, in_commit;
  logic cur_hit, cur_free;
  logic steal_ok;
  logic [SEL_W-1:0] steal_idx;
  logic tgt_ok;
  logic [SEL_W-1:0] tgt_idx;
  logic do_on, do_off, do_all, do_drop;

  assign ev_ready  = (state_q == IDLE);
  assign accept    = ev_valid && ev_ready;
  assign in_scan   = (state_q == SCAN);
  assign in_commit = (state_q == COMMIT);
  assign last      = (idx_q == SEL_W'(NUM_VOICES - 1));
  assign cur_hit   = gate_q[idx_q] && (vnote_q[idx_q] == note_q);
  assign cur_free  = !gate_q[idx_q];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ev_all_off ? COMMIT : SCAN;
      SCAN:    if (last) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tgt_ok  = 1'b0;
    tgt_idx = '0;
    unique case (1'b1)
      hit_ok_q: begin
        tgt_ok  = 1'b1;
        tgt_idx = hit_idx_q;
      end
      !hit_ok_q && free_ok_q: begin
        tgt_ok  = 1'b1;
        tgt_idx = free_idx_q;
      end
      !hit_ok_q && !free_ok_q && steal_ok: begin
        tgt_ok  = 1'b1;
        tgt_idx = steal_idx;
      end
      default: ;
    endcase
  end

  assign do_all  = in_commit && all_q;
  assign do_on   = in_commit && !all_q && on_q && tgt_ok;
  assign do_drop = in_commit && !all_q && on_q && !tgt_ok;
  assign do_off  = in_commit && !all_q && !on_q && hit_ok_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      on_q       <= 1'b0;
      all_q      <= 1'b0;
      note_q     <= '0;
      hit_ok_q   <= 1'b0;
      free_ok_q  <= 1'b0;
      hit_idx_q  <= '0;
      free_idx_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        on_q      <= ev_on;
        all_q     <= ev_all_off;
        note_q    <= ev_note;
        idx_q     <= '0;
        hit_ok_q  <= 1'b0;
        free_ok_q <= 1'b0;
      end else if (in_scan) begin
        idx_q <= last ? '0 : idx_q + 1'b1;
        if (cur_hit && !hit_ok_q) begin
          hit_ok_q  <= 1'b1;
          hit_idx_q <= idx_q;
        end
        if (cur_free && !free_ok_q) begin
          free_ok_q  <= 1'b1;
          free_idx_q <= idx_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_q <= '0;
      for (int i = 0; i < NUM_VOICES; i++) vnote_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (do_all)
          gate_q[i] <= 1'b0;
        else if (do_on && SEL_W'(i) == tgt_idx) begin
          gate_q[i]  <= 1'b1;
          vnote_q[i] <= note_q;
        end else if (do_off && SEL_W'(i) == hit_idx_q)
          gate_q[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sel_q  <= SEL_W'(SEL_ALL_OFF);
      wr_data_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      drop_q <= do_drop;
      if (do_all) begin
        wr_sel_q  <= SEL_W'(SEL_ALL_OFF);
        wr_data_q <= '0;
      end else if (do_on) begin
        wr_sel_q  <= tgt_idx;
        wr_data_q <= {1'b1, note_q};
      end else if (do_off) begin
        wr_sel_q  <= hit_idx_q;
        wr_data_q <= {1'b0, vnote_q[hit_idx_q]};
      end
    end
  end

  assign wr_sel        = wr_sel_q;
  assign wr_data       = wr_data_q;
  assign voices_active = gate_q;
  assign ev_dropped    = drop_q;

`ifdef VOICE_STEAL_EN
  voice_age_tracker #(
    .NUM_VOICES(NUM_VOICES),
    .SEL_W     (SEL_W),
    .AGE_W     (AGE_W)
  ) u_age (
    .clk       (clk),
    .rst_n     (rst_n),
    .scan_clr_i(accept),
    .scan_en_i (in_scan),
    .scan_idx_i(idx_q),
    .gate_i    (gate_q),
    .bump_i    (do_on),
    .bump_idx_i(tgt_idx),
    .clr_all_i (do_all),
    .found_o   (steal_ok),
    .idx_o     (steal_idx)
  );
`else
  localparam int unused_age_w = AGE_W;
  assign steal_ok  = 1'b0;
  assign steal_idx = '0;
`endif

endmodule

// File: tb/tb_voice_allocator.sv
// Randomized bench for voice_allocator against a table-level model.
// Follows VOICE_STEAL_EN the same way as the design.
module tb_voice_allocator;
  localparam int NV = 24;
  localparam int SW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ev_valid = 1'b0;
  logic ev_ready;
  logic ev_on = 1'b0;
  logic [6:0] ev_note = '0;
  logic ev_all_off = 1'b0;
  logic [SW-1:0] wr_sel;
  logic [7:0] wr_data;
  logic [NV-1:0] voices_active;
  logic ev_dropped;

  int errors = 0;
  int checks = 0;

  int mnote [NV];
  int mgate [NV];
  int mage  [NV];
  int exp_sel = 31;
  int exp_data = 0;
  int exp_drop = 0;

  voice_allocator #(.NUM_VOICES(NV), .SEL_W(SW), .AGE_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_on        (ev_on),
    .ev_note      (ev_note),
    .ev_all_off   (ev_all_off),
    .wr_sel       (wr_sel),
    .wr_data      (wr_data),
    .voices_active(voices_active),
    .ev_dropped   (ev_dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NV-1:0] m_active();
    logic [NV-1:0] v;
    for (int i = 0; i < NV; i++) v[i] = (mgate[i] != 0);
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NV; i++) begin
      mnote[i] = 0; mgate[i] = 0; mage[i] = 0;
    end
    exp_sel = 31; exp_data = 0; exp_drop = 0;
  endtask

  task automatic m_apply(bit all, bit on, int note);
    int t;
    t = -1;
    exp_drop = 0;
    if (all) begin
      for (int i = 0; i < NV; i++) begin
        mgate[i] = 0; mage[i] = 0;
      end
      exp_sel = 31; exp_data = 0;
    end else if (on) begin
      for (int i = 0; i < NV && t < 0; i++)
        if (mgate[i] != 0 && mnote[i] == note) t = i;
      for (int i = 0; i < NV && t < 0; i++)
        if (mgate[i] == 0) t = i;
`ifdef VOICE_STEAL_EN
      if (t < 0) begin
        int best;
        best = -1;
        for (int i = 0; i < NV; i++)
          if (mgate[i] != 0 && (best < 0 || mage[i] > mage[best])) best = i;
        t = best;
      end
`endif
      if (t < 0) exp_drop = 1;
      else begin
        for (int i = 0; i < NV; i++)
          if (i != t && mgate[i] != 0 && mage[i] < 255) mage[i]++;
        mage[t] = 0; mnote[t] = note; mgate[t] = 1;
        exp_sel = t; exp_data = 128 + note;
      end
    end else begin
      for (int i = 0; i < NV && t < 0; i++)
        if (mgate[i] != 0 && mnote[i] == note) t = i;
      if (t >= 0) begin
        mgate[t] = 0;
        exp_sel = t; exp_data = mnote[t];
      end
    end
  endtask

  task automatic send(bit all, bit on, int note);
    int n;
    int old_sel, old_data;
    n = 0;
    @(negedge clk);
    while (!ev_ready && n < 100) begin
      @(negedge clk); n++;
    end
    if (!ev_ready) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    ev_valid = 1'b1; ev_all_off = all; ev_on = on; ev_note = 7'(note);
    @(posedge clk); #1;
    ev_valid = 1'b0;
    ev_all_off = 1'($urandom);
    ev_on = 1'($urandom);
    ev_note = 7'($urandom);
    old_sel = exp_sel; old_data = exp_data;
    m_apply(all, on, note);
    if (!all) begin
      repeat (NV) @(posedge clk);
      #1;
      chk("hold_sel", 32'(wr_sel), old_sel);
      chk("hold_data", 32'(wr_data), old_data);
      chk("busy", 32'(ev_ready), 0);
    end
    @(posedge clk); #1;
    ev_all_off = 1'b0;
    chk("wr_sel", 32'(wr_sel), exp_sel);
    chk("wr_data", 32'(wr_data), exp_data);
    chk("active", 32'(voices_active), 32'(m_active()));
    chk("dropped", 32'(ev_dropped), exp_drop);
    chk("ready_back", 32'(ev_ready), 1);
    if (exp_drop != 0) begin
      @(posedge clk); #1;
      chk("drop_pulse_end", 32'(ev_dropped), 0);
    end
  endtask

  initial begin
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sel", 32'(wr_sel), 31);
    chk("rst_data", 32'(wr_data), 0);
    chk("rst_active", 32'(voices_active), 0);
    chk("rst_ready", 32'(ev_ready), 1);
    chk("rst_drop", 32'(ev_dropped), 0);

    send(0, 1, 60);
    chk("on60_sel", 32'(wr_sel), 0);
    chk("on60_data", 32'(wr_data), 32'h BC);
    send(0, 1, 64);
    chk("on64_sel", 32'(wr_sel), 1);
    chk("on64_data", 32'(wr_data), 32'h C0);
    send(1, 0, 0);

    send(0, 1, 60);
    send(0, 1, 60);
    chk("retrig_sel", 32'(wr_sel), 0);
    send(0, 0, 60);
    chk("off_sel", 32'(wr_sel), 0);
    chk("off_data", 32'(wr_data), 32'h 3C);
    chk("off_active", 32'(voices_active), 0);
    send(0, 0, 61);
    chk("nomatch_data", 32'(wr_data), 32'h 3C);

    for (int n = 40; n < 64; n++) send(0, 1, n);
    chk("full", 32'(voices_active), 32'h FF_FFFF);
    send(0, 1, 70);
`ifdef VOICE_STEAL_EN
    chk("steal_sel", 32'(wr_sel), 0);
    chk("steal_data", 32'(wr_data), 32'h C6);
`else
    chk("nosteal_data", 32'(wr_data), 32'h BF);
`endif

    send(1, 0, 0);
    for (int n = 0; n < 5; n++) send(0, 1, 80 + n);
    send(1, 0, 0);
    chk("alloff_sel", 32'(wr_sel), 31);
    send(0, 1, 50);
    chk("after_off_sel", 32'(wr_sel), 0);

    for (int k = 0; k < 80; k++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 6) send(1, 0, 0);
      else if (r < 70) send(0, 1, int'($urandom_range(60, 66)));
      else send(0, 0, int'($urandom_range(60, 66)));
    end

    send(0, 1, 45);
    @(negedge clk);
    ev_valid = 1'b1; ev_all_off = 1'b0; ev_on = 1'b1; ev_note = 7'd99;
    @(posedge clk); #1;
    ev_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sel", 32'(wr_sel), 31);
    chk("arst_data", 32'(wr_data), 0);
    chk("arst_active", 32'(voices_active), 0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst_ready", 32'(ev_ready), 1);
    repeat (30) @(posedge clk);
    #1;
    chk("arst_nocommit_sel", 32'(wr_sel), 31);
    chk("arst_nocommit_act", 32'(voices_active), 0);
    send(0, 1, 77);
    chk("post_rst_sel", 32'(wr_sel), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Upstream feeder of the 24-output voice demux in the synth datapath.
- Accepts note-on, note-off and all-notes-off events. Keeps a per-voice table of note, gate and age, and picks a target voice by sequential scan.
- Drives the demux select/data pair. Each output value is {gate, note[6:0]}, so the demux holds the current note/gate of every voice.
- Select values of NUM_VOICES or above hit the demux default and clear all voices; the all-off select uses this.

Parameters:
- NUM_VOICES, 24, number of voices; legal range 2..31.
- SEL_W, 5, select width; must satisfy 2^SEL_W > NUM_VOICES.
- AGE_W, 8, width of the per-voice saturating age counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ev_valid  in  1  event present.
- ev_ready  out  1  high only in IDLE; an event is accepted on an edge where ev_valid && ev_ready.
- ev_on  in  1  1 = note-on, 0 = note-off; ignored when ev_all_off = 1.
- ev_note  in  7  MIDI note number.
- ev_all_off  in  1  all-notes-off; takes priority over ev_on.
- wr_sel  out  SEL_W  registered select to the demux.
- wr_data  out  8  registered demux data: bit7 = gate, bits 6:0 = note.
- voices_active  out  NUM_VOICES  registered gate bitmap, one bit per voice.
- ev_dropped  out  1  one-cycle pulse when a note-on finds no voice.

Behaviour:
- Reset values (asynchronous on rst_n low):
  - wr_sel = all ones (5'h1F); wr_data = 0. While the clock runs, this makes the demux clear every voice.
  - voices_active = 0; ev_dropped = 0.
  - Table: all notes 0, gates 0, ages 0.
  - FSM in IDLE; scan index 0.
- wr_sel/wr_data hold their last value between commits. The demux re-latching the same value every clock is intended.
- FSM states: IDLE, SCAN, COMMIT.
  - IDLE: ev_ready = 1.
    - Accepted all-off: next edge goes to COMMIT with the all-off action.
    - Accepted on/off: latch ev_on and ev_note, clear the candidate registers, go to SCAN with index 0.
  - SCAN: evaluates one voice per cycle, index 0 to NUM_VOICES-1; on the last index goes to COMMIT.
    - Note-on candidate priority:
      1. Lowest-index voice that is gated with the same note (retrigger).
      2. Lowest-index voice that is not gated (free).
      3. Gated voice with the greatest age; ties go to the lowest index (steal).
    - Note-off candidate: lowest-index voice that is gated with the same note.
  - COMMIT: one cycle; outputs update on the edge that leaves COMMIT; next state is IDLE.
    - Note-on with a candidate: wr_sel = voice, wr_data = {1, note}. That voice's table entry is set to note, gate 1, age 0. Every other gated voice's age increments, saturating at 2^AGE_W-1.
    - Note-off with a match: wr_sel = voice, wr_data = {0, stored note}; gate cleared.
    - Note-off with no match: no write, no table change.
    - Note-on with no candidate: ev_dropped pulses for one cycle; no write.
    - All-off: wr_sel = 5'h1F, wr_data = 0; all gates and ages cleared.
- Latency:
  - On/off event accepted at edge E0: wr_* valid after edge E0 + NUM_VOICES + 1, i.e. edge 25 with defaults.
  - All-off: wr_* valid after edge E0 + 1.
  - The demux output follows one edge after wr_*.
- Throughput: one event per NUM_VOICES+2 cycles (26 with defaults) for on/off events; one per 2 cycles for all-off.
- ev_note and ev_on may change after acceptance; the latched copies are used.
- voices_active mirrors the table gates and updates in the same edge as wr_*.
- Reset asserted mid-scan: the scan aborts with no commit; all state returns to reset values.

Optional Feature:
- Macro: VOICE_STEAL_EN.
- Defined: priority 3 (steal the oldest gated voice) is enabled, so ev_dropped never pulses.
- Undefined: the age counters and age comparator are not built. A note-on with no retrigger or free voice pulses ev_dropped and writes nothing.

Decomposition:
- Package synth_voice_pkg holds:
  - NUM_VOICES_DEF = 24, SEL_W_DEF = 5.
  - SEL_ALL_OFF = 5'h1F, GATE_BIT = 7.
  - FSM state enum {IDLE, SCAN, COMMIT}.
- One sub-module, voice_age_tracker: the per-voice saturating age counters plus the running-maximum comparator. It is instantiated only under VOICE_STEAL_EN.

Test Plan:
- Reset, then 3 clocks idle -> wr_sel = 31, wr_data = 0, voices_active = 0, ev_ready = 1.
- Note-on 60 -> wr_sel = 0, wr_data = 8'hBC after 25 edges; voices_active[0] = 1. Then note-on 64 -> wr_sel = 1, wr_data = 8'hC0.
- Note-on 60 twice, then note-off 60 -> both note-ons use voice 0; the note-off writes wr_sel = 0, wr_data = 8'h3C; voices_active = 0. A further note-off 61 -> no write.
- Note-on notes 40..63 to fill all 24 voices, then note-on 70:
  - With VOICE_STEAL_EN: voice 0 (the oldest) gets wr_data = 8'hC6.
  - Without: ev_dropped pulses once and wr_* is unchanged.
- All-off with 5 voices active -> wr_sel = 31, wr_data = 0 after 1 edge; voices_active = 0; the next note-on 50 goes to voice 0.
- rst_n pulsed low for 1 cycle mid-scan -> no commit; the outputs show reset values immediately (asynchronously); ev_ready = 1 after release.
